delay_credit_fifo: RTL and testbench

Elastic buffer that sits directly downstream of the fixed-latency delay line. The delay line has no backpressure, so this block issues credits to the source feeding the delay line. It counts items in flight through the LATENCY-cycle pipe. Arriving data is stored and presented to the consumer on a valid/ready interface, so a stalled consumer never causes data loss.

---
 rtl/delay_credit_fifo.sv | 71 +++++++
 tb/tb_delay_credit_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_credit_fifo.sv
// delay_credit_fifo: credit-issuing elastic buffer behind a fixed-latency delay line.
// Tracks items in flight through the pipe and stores arrivals for a valid/ready consumer.
module delay_credit_fifo #(
  parameter int WIDTH   = 14,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 6,
  parameter int CNT_W   = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             reset,
  output logic             src_ready,
  input  logic             src_issue,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] inflight,
  output logic             overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 256 || LATENCY < 0) begin : g_bad_param
    $error("delay_credit_fifo: DEPTH must be 2..256 and LATENCY non-negative");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, r_inflight;
  logic             r_overflow;
  logic             w_rd, w_wr, w_full, w_inc, w_dec;
  logic [CNT_W:0]   w_total;

  always_comb begin
    w_full    = r_count == FULL;
    out_valid = r_count != '0;
    w_rd      = out_valid & out_ready;
    // a pop frees the slot in the same cycle, so a full queue still takes the arrival
    w_wr      = in_valid & (~w_full | w_rd);
    w_inc     = src_issue & ~in_valid & (r_inflight != FULL);
    w_dec     = in_valid & ~src_issue & (r_inflight != '0);
    w_total   = {1'b0, r_count} + {1'b0, r_inflight};
    src_ready = w_total < {1'b0, FULL};
    out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    count     = r_count;
    inflight  = r_inflight;
    overflow  = r_overflow;
  end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= in_data;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr ? (r_wr_ptr == LAST ? '0 : r_wr_ptr + 1'b1) : r_wr_ptr;
      r_rd_ptr   <= w_rd ? (r_rd_ptr == LAST ? '0 : r_rd_ptr + 1'b1) : r_rd_ptr;
      r_count    <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
      r_inflight <= r_inflight + CNT_W'(w_inc) - CNT_W'(w_dec);
      // dropped data or an arrival nobody issued
      r_overflow <= r_overflow | (in_valid & ~w_wr) | (in_valid & (r_inflight == '0));
    end
endmodule

// File: tb/tb_delay_credit_fifo.sv
// tb_delay_credit_fifo: directed bench with a modelled 6-cycle delay line and a data scoreboard.
module tb_delay_credit_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        src_ready, src_issue = 1'b0, in_valid = 1'b0, out_valid, out_ready = 1'b0, overflow;
  logic [13:0] in_data = '0, out_data;
  logic [3:0]  count, inflight;

  logic        p_v [6];
  logic [13:0] p_d [6];
  logic [13:0] sb [$];
  int          mcount = 0, total = 0, bad = 0, npop = 0;
  logic        chk_inv = 1'b0;
  logic [13:0] nd = 14'd1;

  delay_credit_fifo #(.WIDTH(14), .DEPTH(8), .LATENCY(6)) dut (
    .clk(clk), .reset(reset), .src_ready(src_ready), .src_issue(src_issue),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .inflight(inflight), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
      else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      npop++;
    end
    if (chk_inv) chk("credit_bound", 32'(count + inflight <= 5'd8), 32'd1);
  end

  function automatic logic pipe_busy();
    logic b = 1'b0;
    for (int i = 0; i < 6; i++) b |= p_v[i];
    return b;
  endfunction

  // one clock: drive inputs, update the acceptance model, advance the delay line
  task automatic tick(input logic iss, input logic [13:0] d, input logic rdy);
    logic pop;
    src_issue = iss;
    out_ready = rdy;
    in_valid  = p_v[5];
    in_data   = p_d[5];
    pop = (mcount != 0) && rdy;
    if (in_valid && (mcount < 8 || pop)) begin
      sb.push_back(in_data);
      mcount++;
    end
    if (pop) mcount--;
    @(posedge clk);
    #1;
    for (int i = 5; i > 0; i--) begin
      p_v[i] = p_v[i-1];
      p_d[i] = p_d[i-1];
    end
    p_v[0] = iss;
    p_d[0] = d;
    src_issue = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mcount = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issued;
    for (int i = 0; i < 6; i++) begin
      p_v[i] = 1'b0;
      p_d[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(0, 0, 0);
    chk("idle_src_ready", 32'(src_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      tick(1, nd, 0);
      nd++;
      if (i == 6) chk("fill_ready_7th", 32'(src_ready), 32'd1);
    end
    chk("fill_ready_8th", 32'(src_ready), 32'd0);
    repeat (6) tick(0, 0, 0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_inflight", 32'(inflight), 32'd0);
    chk("fill_src_ready", 32'(src_ready), 32'd0);
    chk("fill_overflow", 32'(overflow), 32'd0);
    chk("fill_head", 32'(out_data), 32'h1);

    repeat (3) tick(0, 0, 1);
    chk("pop3_count", 32'(count), 32'd5);
    chk("pop3_src_ready", 32'(src_ready), 32'd1);
    chk("pop3_head", 32'(out_data), 32'h4);

    for (int i = 0; i < 3; i++) begin
      tick(1, nd, 0);
      nd++;
    end
    repeat (6) tick(0, 0, 0);
    chk("refill_count", 32'(count), 32'd8);
    tick(1, 14'h00AA, 0);
    chk("bad_issue_inflight", 32'(inflight), 32'd1);
    chk("bad_issue_overflow", 32'(overflow), 32'd0);
    repeat (5) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("fullpop_count", 32'(count), 32'd8);
    chk("fullpop_inflight", 32'(inflight), 32'd0);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(out_data), 32'h5);

    tick(1, 14'h00BB, 0);
    repeat (5) tick(0, 0, 0);
    tick(0, 0, 0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_inflight", 32'(inflight), 32'd0);
    repeat (8) tick(0, 0, 1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_overflow_sticky", 32'(overflow), 32'd1);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    do_reset();
    chk("rst2_overflow", 32'(overflow), 32'd0);
    chk_inv = 1'b1;
    npop = 0;
    issued = 0;
    for (int c = 0; c < 2000 && issued < 24; c++) begin
      logic iss;
      iss = src_ready && ($urandom_range(0, 1) == 1);
      tick(iss, nd, $urandom_range(0, 1) == 1);
      if (iss) begin
        nd++;
        issued++;
      end
    end
    for (int c = 0; c < 200 && (mcount != 0 || pipe_busy()); c++) tick(0, 0, 1);
    chk_inv = 1'b0;
    chk("wrap_issued", 32'(issued), 32'd24);
    chk("wrap_pops", 32'(npop), 32'd24);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_inflight", 32'(inflight), 32'd0);
    chk("wrap_overflow", 32'(overflow), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 6; i++) tick(1, 14'h100 + 14'(i), 0);
    repeat (4) tick(0, 0, 0);
    chk("mid_count", 32'(count), 32'd4);
    chk("mid_inflight", 32'(inflight), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_inflight", 32'(inflight), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_src_ready", 32'(src_ready), 32'd1);
    mcount = 0;
    sb.delete();
    #3;
    reset = 1'b1;
    repeat (2) tick(0, 0, 0);
    chk("late_overflow", 32'(overflow), 32'd1);
    chk("late_count", 32'(count), 32'd2);
    chk("late_inflight", 32'(inflight), 32'd0);
    repeat (2) tick(0, 0, 1);
    chk("late_sb_empty", 32'(sb.size()), 32'd0);
    chk("late_drained", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
